crc_128_arb: RTL

CRC_128_ARB -- requirements
Module: crc_128_arb

---
 rtl/crc_128_arb_if.sv | 34 +++
 rtl/crc_128_arb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/crc_128_arb_if.sv
// Bundle of request, encoder and response signals between crc_128_arb and its neighbours.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface crc_128_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 128,
   parameter int CW   = 134
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               enc_enable;
   logic [DW-1:0]      enc_data;
   logic [CW-1:0]      enc_code;
   logic               enc_valid;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   logic [CW-1:0]      rsp_code;
   logic               rsp_err;
   logic               busy;
   logic [15:0]        done_cnt;

   modport slave (
      input  req_valid, req_data, enc_code, enc_valid, rsp_ready,
      output req_ready, enc_enable, enc_data, rsp_valid, rsp_id, rsp_code, rsp_err, busy, done_cnt
   );

   modport master (
      output req_valid, req_data, enc_code, enc_valid, rsp_ready,
      input  req_ready, enc_enable, enc_data, rsp_valid, rsp_id, rsp_code, rsp_err, busy, done_cnt
   );
endinterface

// File: rtl/crc_128_arb.sv
// Round-robin arbiter that shares one crc_128_enc among NREQ requesters.
// Each transaction holds its response until the consumer accepts it, and a stalled encoder times out.
module crc_128_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 128,
   parameter int CW   = 134,
   parameter int TMO  = 15
) (
   input  logic           clk,
   input  logic           reset,
   crc_128_arb_if.slave   bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_last;
   logic [NREQ-1:0] r_req_ready;
   logic [DW-1:0]   r_enc_data;
   logic [IW-1:0]   r_rsp_id;
   logic [CW-1:0]   r_rsp_code;
   logic            r_rsp_err;
   logic [15:0]     r_done_cnt;
   logic [TW-1:0]   r_tmo;

   logic            w_gnt_found;
   logic [IW-1:0]   w_gnt_idx;
   logic            w_hi_found;
   logic [IW-1:0]   w_hi_idx;
   logic [IW-1:0]   w_lo_idx;
   logic            w_tmo_hit;

   assign w_tmo_hit = (r_tmo == TW'(TMO));

   // Round robin: take the lowest pending index above last_grant, otherwise wrap to the lowest pending index.
   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      w_gnt_found = |bus.req_valid;
      w_hi_found  = 1'b0;
      w_hi_idx    = '0;
      w_lo_idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            w_lo_idx = IW'(i);
            if (IW'(i) > r_last) begin
               w_hi_found = 1'b1;
               w_hi_idx   = IW'(i);
            end
         end
      end
      w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt_found) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (bus.enc_valid || w_tmo_hit) w_next = S_HOLD;
         S_HOLD:  if (bus.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only, so flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: there is no memory array here. Every register, including the wide data paths, is reset to a known value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last      <= IW'(NREQ - 1);
         r_req_ready <= '0;
         r_enc_data  <= '0;
         r_rsp_id    <= '0;
         r_rsp_code  <= '0;
         r_rsp_err   <= 1'b0;
         r_done_cnt  <= '0;
         r_tmo       <= '0;
      end else begin
         r_req_ready <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_found) begin
                  r_req_ready[w_gnt_idx] <= 1'b1;
                  r_enc_data             <= bus.req_data[int'(w_gnt_idx) * DW +: DW];
                  r_rsp_id               <= w_gnt_idx;
                  r_last                 <= w_gnt_idx;
               end
            end
            S_ISSUE: r_tmo <= '0;
            S_WAIT: begin
               r_tmo <= r_tmo + 1'b1;
               // A code word that arrives on the timeout cycle still wins.
               if (bus.enc_valid) begin
                  r_rsp_code <= bus.enc_code;
                  r_rsp_err  <= 1'b0;
               end else if (w_tmo_hit) begin
                  r_rsp_code <= '0;
                  r_rsp_err  <= 1'b1;
               end
            end
            S_HOLD: if (bus.rsp_ready) r_done_cnt <= r_done_cnt + 16'd1;
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.enc_enable = (r_state == S_ISSUE);
   assign bus.enc_data   = r_enc_data;
   assign bus.rsp_valid  = (r_state == S_HOLD);
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_code   = r_rsp_code;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done_cnt   = r_done_cnt;
endmodule
